// File: rtl/axioma_io_pkg.sv
// axioma_io_pkg: I/O register map, clock-select encodings and flag/mask bit
// positions shared by the input-capture unit and the timers.
package axioma_io_pkg;

  localparam logic [5:0] ADDR_ICCTRL = 6'h30;
  localparam logic [5:0] ADDR_CNTL   = 6'h31;
  localparam logic [5:0] ADDR_CNTH   = 6'h32;
  localparam logic [5:0] ADDR_ICRL   = 6'h33;
  localparam logic [5:0] ADDR_ICRH   = 6'h34;
  localparam logic [5:0] ADDR_ICMSK  = 6'h35;
  localparam logic [5:0] ADDR_ICFLG  = 6'h36;

  localparam int ICCTRL_ICES = 6;
  localparam int ICCTRL_ICNC = 7;

  localparam int FLG_TOV = 0;
  localparam int FLG_ICF = 1;
  localparam int FLG_OVR = 2;

  localparam int MSK_TOIE = 0;
  localparam int MSK_ICIE = 1;

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_DIV1    = 3'b001,
    CS_DIV8    = 3'b010,
    CS_DIV64   = 3'b011,
    CS_DIV256  = 3'b100,
    CS_DIV1024 = 3'b101,
    CS_STOP_6  = 3'b110,
    CS_STOP_7  = 3'b111
  } cs_e;

  // True for the clock-select codes that actually run the timer.
  function automatic logic cs_running(input logic [2:0] cs);
    logic run;
    case (cs_e'(cs))
      CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: run = 1'b1;
      default:                                           run = 1'b0;
    endcase
    return run;
  endfunction

  // Prescaler count at which the tick fires (divisor - 1).
  function automatic logic [9:0] cs_terminal(input logic [2:0] cs);
    logic [9:0] term;
    case (cs_e'(cs))
      CS_DIV1:    term = 10'd0;
      CS_DIV8:    term = 10'd7;
      CS_DIV64:   term = 10'd63;
      CS_DIV256:  term = 10'd255;
      CS_DIV1024: term = 10'd1023;
      default:    term = 10'd0;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/axioma_prescaler.sv
// axioma_prescaler: clock-select divider producing a single-clk tick, shared
// by the input-capture unit and the timers.
module axioma_prescaler
  import axioma_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] cs,
  input  logic       clr,
  output logic       tick
);

  logic [9:0] count;
  logic [9:0] terminal;
  logic       running;

  assign terminal = cs_terminal(cs);
  assign running  = cs_running(cs);
  assign tick     = running && (count == terminal);

  // Divider count; held at zero while stopped or when the owner clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 10'd0;
    end else if (clr || !running) begin
      count <= 10'd0;
    end else if (count == terminal) begin
      count <= 10'd0;
    end else begin
      count <= count + 10'd1;
    end
  end

endmodule

// File: rtl/axioma_input_capture.sv
// axioma_input_capture: 16-bit timer with edge-triggered input capture on icp_pin.
// Define AXIOMA_ICP_NOISE_CANCEL_EN to build the 4-sample noise canceler (ICNC).
module axioma_input_capture
  import axioma_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  io_addr,
  input  logic [7:0]  io_data_in,
  input  logic        io_read,
  input  logic        io_write,
  output logic [7:0]  io_data_out,
  input  logic        icp_pin,
  output logic        capture_irq,
  output logic        overflow_irq,
  output logic [15:0] debug_count
);

`ifdef AXIOMA_ICP_NOISE_CANCEL_EN
  localparam logic [7:0] ICCTRL_WMASK = 8'hFF;
`else
  localparam logic [7:0] ICCTRL_WMASK = 8'h7F;
`endif

  logic [7:0]  icctrl;
  logic [15:0] cnt;
  logic [15:0] icr;
  logic [7:0]  temp;
  logic [1:0]  icmsk;
  logic [2:0]  icflg;
  logic        sync1;
  logic        sync2;
  logic        filt;
  logic        filt_prev;
  logic        filt_next;

  logic wr_icctrl, wr_cntl, wr_cnth, wr_icmsk, wr_icflg;
  logic rd_cntl, rd_icrl;
  logic tick, capture, tov_set;
  logic [2:0] set_flags, clr_flags;

  assign wr_icctrl = io_write && (io_addr == ADDR_ICCTRL);
  assign wr_cntl   = io_write && (io_addr == ADDR_CNTL);
  assign wr_cnth   = io_write && (io_addr == ADDR_CNTH);
  assign wr_icmsk  = io_write && (io_addr == ADDR_ICMSK);
  assign wr_icflg  = io_write && (io_addr == ADDR_ICFLG);
  assign rd_cntl   = io_read  && (io_addr == ADDR_CNTL);
  assign rd_icrl   = io_read  && (io_addr == ADDR_ICRL);

  axioma_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (icctrl[2:0]),
    .clr     (wr_icctrl),
    .tick    (tick)
  );

  // A filtered-level change in the ICES direction captures; ICES writes alone never do.
  assign capture = (filt != filt_prev) && (filt == icctrl[ICCTRL_ICES]);
  assign tov_set = tick && !wr_cntl && (cnt == 16'hFFFF);

  assign capture_irq  = icflg[FLG_ICF] & icmsk[MSK_ICIE];
  assign overflow_irq = icflg[FLG_TOV] & icmsk[MSK_TOIE];
  assign debug_count  = cnt;

`ifdef AXIOMA_ICP_NOISE_CANCEL_EN
  logic [3:0] hist;

  // Last four synchronized samples for the noise canceler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= 4'b0000;
    end else begin
      hist <= {hist[2:0], sync2};
    end
  end

  // With ICNC the level only follows four agreeing samples, otherwise it tracks sync2.
  always_comb begin
    filt_next = filt;
    if (icctrl[ICCTRL_ICNC]) begin
      if (hist == 4'b1111) begin
        filt_next = 1'b1;
      end else if (hist == 4'b0000) begin
        filt_next = 1'b0;
      end else begin
        filt_next = filt;
      end
    end else begin
      filt_next = sync2;
    end
  end
`else
  assign filt_next = sync2;
`endif

  // Pin synchronizer and filtered-level history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
    end else begin
      sync1     <= icp_pin;
      sync2     <= sync1;
      filt      <= filt_next;
      filt_prev <= filt;
    end
  end

  // Counter: a CNTL write commits {TEMP, data} and beats the same-cycle tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 16'h0000;
    end else if (wr_cntl) begin
      cnt <= {temp, io_data_in};
    end else if (tick) begin
      cnt <= cnt + 16'h0001;
    end else begin
      cnt <= cnt;
    end
  end

  // Capture register takes the pre-increment counter of the detecting cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icr <= 16'h0000;
    end else if (capture) begin
      icr <= cnt;
    end else begin
      icr <= icr;
    end
  end

  // TEMP shared by both 16-bit registers: loaded by CNTH writes and low-byte reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp <= 8'h00;
    end else if (wr_cnth) begin
      temp <= io_data_in;
    end else if (rd_cntl) begin
      temp <= cnt[15:8];
    end else if (rd_icrl) begin
      temp <= icr[15:8];
    end else begin
      temp <= temp;
    end
  end

  // Flag set/clear masks; hardware sets are OR-ed in after the write-1 clear.
  always_comb begin
    set_flags          = 3'b000;
    set_flags[FLG_TOV] = tov_set;
    set_flags[FLG_ICF] = capture;
    set_flags[FLG_OVR] = capture & icflg[FLG_ICF];
    if (wr_icflg) begin
      clr_flags = io_data_in[2:0];
    end else begin
      clr_flags = 3'b000;
    end
  end

  // Control, mask and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icctrl <= 8'h00;
      icmsk  <= 2'b00;
      icflg  <= 3'b000;
    end else begin
      if (wr_icctrl) begin
        icctrl <= io_data_in & ICCTRL_WMASK;
      end else begin
        icctrl <= icctrl;
      end
      if (wr_icmsk) begin
        icmsk <= io_data_in[1:0];
      end else begin
        icmsk <= icmsk;
      end
      icflg <= (icflg & ~clr_flags) | set_flags;
    end
  end

  // Read mux; high bytes come from TEMP so 16-bit reads stay coherent.
  always_comb begin
    io_data_out = 8'h00;
    if (io_read) begin
      case (io_addr)
        ADDR_ICCTRL: io_data_out = icctrl;
        ADDR_CNTL:   io_data_out = cnt[7:0];
        ADDR_CNTH:   io_data_out = temp;
        ADDR_ICRL:   io_data_out = icr[7:0];
        ADDR_ICRH:   io_data_out = temp;
        ADDR_ICMSK:  io_data_out = {6'b000000, icmsk};
        ADDR_ICFLG:  io_data_out = {5'b00000, icflg};
        default:     io_data_out = 8'h00;
      endcase
    end else begin
      io_data_out = 8'h00;
    end
  end

endmodule

// File: tb/tb_axioma_input_capture.sv
// tb_axioma_input_capture: directed stimulus against a behavioural model of the
// capture timer, plus hand-computed literal expectations.
module tb_axioma_input_capture;

  localparam logic [5:0] A_CTRL = 6'h30, A_CNTL = 6'h31, A_CNTH = 6'h32, A_ICRL = 6'h33;
  localparam logic [5:0] A_ICRH = 6'h34, A_MSK  = 6'h35, A_FLG  = 6'h36;
`ifdef AXIOMA_ICP_NOISE_CANCEL_EN
  localparam bit HAS_NC = 1'b1;
`else
  localparam bit HAS_NC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  io_addr = 6'h00;
  logic [7:0]  io_data_in = 8'h00;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [7:0]  io_data_out;
  logic        icp_pin = 1'b0;
  logic        capture_irq;
  logic        overflow_irq;
  logic [15:0] debug_count;

  int checks = 0;
  int fails = 0;

  axioma_input_capture dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_addr      (io_addr),
    .io_data_in   (io_data_in),
    .io_read      (io_read),
    .io_write     (io_write),
    .io_data_out  (io_data_out),
    .icp_pin      (icp_pin),
    .capture_irq  (capture_irq),
    .overflow_irq (overflow_irq),
    .debug_count  (debug_count)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0]  m_ctrl;
  logic [15:0] m_cnt, m_icr;
  logic [7:0]  m_temp;
  logic [1:0]  m_msk;
  logic [2:0]  m_flg;
  int          m_pres;
  logic [5:0]  m_samp;   // pin samples, [0] = most recent edge
  logic        m_lvl, m_lvl_prev;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int divisor(input logic [2:0] cs);
    case (cs)
      3'd1: return 1;
      3'd2: return 8;
      3'd3: return 64;
      3'd4: return 256;
      3'd5: return 1024;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      A_CTRL: return m_ctrl;
      A_CNTL: return m_cnt[7:0];
      A_CNTH: return m_temp;
      A_ICRL: return m_icr[7:0];
      A_ICRH: return m_temp;
      A_MSK:  return {6'd0, m_msk};
      A_FLG:  return {5'd0, m_flg};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_cnt = 16'h0; m_icr = 16'h0; m_temp = 8'h00; m_msk = 2'b00;
    m_flg = 3'b000; m_pres = 0; m_samp = 6'b0; m_lvl = 1'b0; m_lvl_prev = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  task automatic model_step();
    int   div;
    bit   tick, cap;
    bit   w, r;
    logic [2:0] setb, clrb;
    logic new_lvl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    w = io_write; r = io_read;
    div  = divisor(m_ctrl[2:0]);
    tick = (div != 0) && (m_pres == div - 1);
    cap  = (m_lvl != m_lvl_prev) && (m_lvl == m_ctrl[6]);
    setb = 3'b000;
    if (cap) begin
      setb[1] = 1'b1;
      if (m_flg[1]) setb[2] = 1'b1;
    end
    if (w && io_addr == A_CNTH) m_temp = io_data_in;
    else if (r && io_addr == A_CNTL) m_temp = m_cnt[15:8];
    else if (r && io_addr == A_ICRL) m_temp = m_icr[15:8];
    if (cap) m_icr = m_cnt;
    if (w && io_addr == A_CNTL) begin
      m_cnt = {m_temp_before(), io_data_in};
    end else if (tick) begin
      if (m_cnt == 16'hFFFF) setb[0] = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end
    clrb = (w && io_addr == A_FLG) ? io_data_in[2:0] : 3'b000;
    m_flg = (m_flg & ~clrb) | setb;
    if ((w && io_addr == A_CTRL) || div == 0 || tick) m_pres = 0;
    else m_pres = m_pres + 1;
    if (HAS_NC && m_ctrl[7])
      new_lvl = (m_samp[5:2] == 4'b1111) ? 1'b1 : (m_samp[5:2] == 4'b0000) ? 1'b0 : m_lvl;
    else
      new_lvl = m_samp[1];
    m_lvl_prev = m_lvl;
    m_lvl = new_lvl;
    m_samp = {m_samp[4:0], icp_pin};
    if (w && io_addr == A_CTRL) m_ctrl = HAS_NC ? io_data_in : {1'b0, io_data_in[6:0]};
    if (w && io_addr == A_MSK) m_msk = io_data_in[1:0];
  endtask

  // A CNTH write and CNTL write never share a cycle, so TEMP here is the pre-edge value.
  function automatic logic [7:0] m_temp_before();
    return m_temp;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of the live outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        check("rst_count", debug_count, 16'h0000);
        check("rst_cirq", {15'd0, capture_irq}, 16'h0000);
        check("rst_oirq", {15'd0, overflow_irq}, 16'h0000);
      end else begin
        check("count", debug_count, m_cnt);
        check("cirq", {15'd0, capture_irq}, {15'd0, m_flg[1] & m_msk[1]});
        check("oirq", {15'd0, overflow_irq}, {15'd0, m_flg[0] & m_msk[0]});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_addr = a; io_data_in = d; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0; io_addr = 6'h00; io_data_in = 8'h00;
  endtask

  task automatic rd_m(input logic [5:0] a, input string name);
    io_addr = a; io_read = 1'b1;
    #1;
    check({name, "_model"}, {8'd0, io_data_out}, {8'd0, m_read(a)});
    @(negedge clk);
    io_read = 1'b0; io_addr = 6'h00;
  endtask

  task automatic rd_lit(input logic [5:0] a, input logic [7:0] exp, input string name);
    io_addr = a; io_read = 1'b1;
    #1;
    check(name, {8'd0, io_data_out}, {8'd0, exp});
    check({name, "_model"}, {8'd0, io_data_out}, {8'd0, m_read(a)});
    @(negedge clk);
    io_read = 1'b0; io_addr = 6'h00;
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(1);
    // Reset values
    rd_lit(A_CTRL, 8'h00, "rst_ctrl");
    rd_lit(A_CNTL, 8'h00, "rst_cntl");
    rd_lit(A_CNTH, 8'h00, "rst_cnth");
    rd_lit(A_ICRL, 8'h00, "rst_icrl");
    rd_lit(A_ICRH, 8'h00, "rst_icrh");
    rd_lit(A_MSK,  8'h00, "rst_msk");
    rd_lit(A_FLG,  8'h00, "rst_flg");
    // ICNC write, reserved bits, unmapped and idle reads
    wr(A_CTRL, 8'hBF);
    rd_lit(A_CTRL, HAS_NC ? 8'hBF : 8'h3F, "ctrl_rw");
    io_addr = A_CTRL; #1;
    check("rd_idle", {8'd0, io_data_out}, 16'h0000);
    @(negedge clk);
    rd_lit(6'h37, 8'h00, "unmapped37");
    rd_lit(6'h00, 8'h00, "unmapped00");
    idle(5);
    wr(A_CTRL, 8'h00);
    wr(A_MSK, 8'h03);
    rd_lit(A_MSK, 8'h03, "msk_rw");
    // Counter load through TEMP, ICR read-only
    wr(A_CNTH, 8'h01);
    wr(A_CNTL, 8'h00);
    rd_lit(A_CNTL, 8'h00, "cnt_lo");
    rd_lit(A_CNTH, 8'h01, "cnt_hi");
    wr(A_ICRL, 8'h55);
    wr(A_ICRH, 8'h66);
    rd_lit(A_ICRL, 8'h00, "icr_ro_lo");
    rd_lit(A_ICRH, 8'h00, "icr_ro_hi");
    // Capture at 0x0100 + 2 with 3-clk latency
    icp_pin = 1'b1;
    wr(A_CTRL, 8'h41);
    idle(2); #1;
    check("lat_e2", {15'd0, capture_irq}, 16'h0000);
    idle(1); #1;
    check("lat_e3", {15'd0, capture_irq}, 16'h0001);
    rd_lit(A_ICRL, 8'h02, "cap_lo");
    rd_lit(A_ICRH, 8'h01, "cap_hi");
    // Second rising edge without clear -> OVR
    icp_pin = 1'b0; idle(5);
    icp_pin = 1'b1; idle(5);
    rd_lit(A_FLG, 8'h06, "ovr_flags");
    rd_m(A_ICRL, "ovr_icrl");
    rd_m(A_ICRH, "ovr_icrh");
    wr(A_FLG, 8'h07);
    rd_lit(A_FLG, 8'h00, "flg_clear");
    // Wrap: TOV set wins over same-cycle clear
    wr(A_CNTH, 8'hFF);
    wr(A_CNTL, 8'hFE); #1;
    check("cnt_fffe", debug_count, 16'hFFFE);
    @(negedge clk);
    wr(A_FLG, 8'h01); #1;
    check("wrap_cnt", debug_count, 16'h0000);
    check("wrap_oirq", {15'd0, overflow_irq}, 16'h0001);
    rd_lit(A_FLG, 8'h01, "tov_wins");
    // CNTL write beats the tick and suppresses TOV
    wr(A_FLG, 8'h01);
    wr(A_CNTH, 8'hFF);
    wr(A_CNTL, 8'hFE);
    @(negedge clk);
    wr(A_CNTL, 8'h10); #1;
    check("cntl_prio", debug_count, 16'hFF10);
    rd_lit(A_FLG, 8'h00, "tov_suppr");
    // Atomic ICR read across a later capture, capture while stopped
    wr(A_CTRL, 8'h40);
    icp_pin = 1'b0; idle(5);
    wr(A_FLG, 8'h07);
    wr(A_CNTH, 8'h12);
    wr(A_CNTL, 8'hAB);
    icp_pin = 1'b1; idle(5);
    rd_lit(A_ICRL, 8'hAB, "atomic_lo");
    wr(A_CTRL, 8'h41);
    icp_pin = 1'b0; idle(5);
    icp_pin = 1'b1; idle(5);
    wr(A_CTRL, 8'h40);
    rd_lit(A_ICRH, 8'h12, "atomic_hi");
    rd_m(A_ICRL, "second_lo");
    rd_m(A_ICRH, "second_hi");
    rd_lit(A_FLG, 8'h06, "atomic_flags");
    // ICES toggling with pin high, then falling capture
    wr(A_CTRL, 8'h01);
    wr(A_FLG, 8'h07);
    idle(5);
    wr(A_CTRL, 8'h41);
    idle(2);
    wr(A_CTRL, 8'h01);
    idle(5);
    rd_lit(A_FLG, 8'h00, "ices_nocap");
    icp_pin = 1'b0; idle(5);
    rd_lit(A_FLG, 8'h02, "fall_cap");
    // Prescaler divisors
    wr(A_FLG, 8'h07);
    wr(A_CTRL, 8'h00);
    wr(A_CNTH, 8'h00);
    wr(A_CNTL, 8'h00);
    wr(A_CTRL, 8'h02);
    idle(16); #1;
    check("div8", debug_count, 16'h0002);
    wr(A_CTRL, 8'h03); idle(150);
    wr(A_CTRL, 8'h06); idle(10);
    wr(A_CTRL, 8'h05); idle(1100);
    wr(A_CTRL, 8'h04); idle(300);
    // Reset mid-capture discards the edge
    wr(A_CTRL, 8'h40);
    wr(A_FLG, 8'h07);
    icp_pin = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    idle(3);
    icp_pin = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(8);
    rd_lit(A_FLG, 8'h00, "rst_midcap");
    rd_lit(A_CTRL, 8'h00, "rst_ctrl2");
    // Pin high at reset release reads as a rising edge
    reset_n = 1'b0;
    icp_pin = 1'b1;
    idle(3);
    reset_n = 1'b1;
    wr(A_CTRL, 8'h40);
    idle(4);
    rd_lit(A_FLG, 8'h02, "rel_rise");
    rd_lit(A_ICRL, 8'h00, "rel_icr");
`ifdef AXIOMA_ICP_NOISE_CANCEL_EN
    wr(A_CTRL, 8'hC0);
    wr(A_MSK, 8'h02);
    icp_pin = 1'b0; idle(10);
    wr(A_FLG, 8'h07);
    icp_pin = 1'b1; idle(3);
    icp_pin = 1'b0; idle(12);
    rd_lit(A_FLG, 8'h00, "nc_glitch3");
    icp_pin = 1'b1; idle(4);
    icp_pin = 1'b0; idle(3); #1;
    check("nc_lat6", {15'd0, capture_irq}, 16'h0000);
    idle(1); #1;
    check("nc_lat7", {15'd0, capture_irq}, 16'h0001);
    idle(10);
`endif
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axioma_input_capture.md
AXIOMA_INPUT_CAPTURE -- requirements
Module: axioma_input_capture

Interface
REQ-001 SHALL have port clk, input, 1, system clock (16 MHz).
REQ-002 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have ports io_addr (input, 6), io_data_in (input, 8), io_read (input, 1) and io_write (input, 1); these form the CPU I/O bus.
REQ-004 SHALL have port io_data_out, output, 8; combinational read data, 0x00 when io_read=0 or the address is unmapped.
REQ-005 SHALL have port icp_pin, input, 1; asynchronous external capture input.
REQ-006 SHALL have ports capture_irq and overflow_irq, output, 1 each; capture_irq = ICF & ICIE, overflow_irq = TOV & TOIE.
REQ-007 SHALL have port debug_count, output, 16; live counter value.
REQ-008 SHALL decode these registers: ICCTRL 0x30, CNTL 0x31, CNTH 0x32, ICRL 0x33, ICRH 0x34, ICMSK 0x35, ICFLG 0x36.

Function
REQ-009 ICCTRL fields SHALL be: [2:0] CS, [6] ICES (1 = rising edge, 0 = falling edge), [7] ICNC; bits [5:3] are read/write with no function.
REQ-010 CS encodings SHALL be: 000 stop, 001 /1, 010 /8, 011 /64, 100 /256, 101 /1024, 11x stop; the timer tick is a single-clk pulse.
REQ-011 The prescaler count SHALL clear to 0 on any ICCTRL write and while the timer is stopped.
REQ-012 The 16-bit counter SHALL increment on each tick and wrap from 0xFFFF to 0x0000; the wrap SHALL set TOV (ICFLG[0]).
REQ-013 icp_pin SHALL pass through a 2-FF synchronizer, and edge detection SHALL compare the filtered level against its previous value.
REQ-014 On a detected edge that matches ICES, ICR SHALL load the counter value of that cycle and ICF (ICFLG[1]) SHALL set.
REQ-015 Capture latency SHALL be exactly 3 clk from the first clk edge sampling the new pin level to the ICR update, with the noise canceler off.
REQ-016 A capture while ICF is already 1 SHALL overwrite ICR and set OVR (ICFLG[2]).
REQ-017 Writing ICES SHALL NOT by itself cause a capture.
REQ-018 Captures SHALL occur when CS is stop, and SHALL latch the held counter value.
REQ-019 ICMSK fields SHALL be: [0] TOIE, [1] ICIE.
REQ-020 ICFLG bits SHALL clear when 1 is written to them; a hardware set in the same cycle as a clear SHALL win.
REQ-021 16-bit reads of CNT and ICR SHALL be atomic: a read of L returns the low byte and latches the matching high byte into TEMP at that clk edge; a read of H returns TEMP.
REQ-022 16-bit writes to CNT SHALL go through TEMP: a write to CNTH loads TEMP; a write to CNTL commits {TEMP, data} to the counter.
REQ-023 A CNTL write SHALL take priority over a same-cycle tick increment and SHALL suppress that cycle's TOV set.
REQ-024 ICR SHALL be read-only; writes to ICRL and ICRH SHALL be ignored.

Reset
REQ-025 Under reset_n=0, all registers, TEMP, the counter, the prescaler, the synchronizer and the filter SHALL be 0x00/0.
REQ-026 Under reset_n=0, capture_irq, overflow_irq and debug_count SHALL be 0.
REQ-027 Reset asserted mid-capture SHALL discard the pending edge, and no ICF SHALL be set after release.
REQ-028 The synchronizer SHALL leave reset at 0, so a pin held high at reset release SHALL be detected as a rising edge.

Configuration
REQ-029 With AXIOMA_ICP_NOISE_CANCEL_EN defined and ICNC=1, the filtered level SHALL change only after 4 consecutive equal synchronized samples, adding exactly 4 clk of capture latency.
REQ-030 With AXIOMA_ICP_NOISE_CANCEL_EN defined and ICNC=1, glitches shorter than 4 clk SHALL NOT capture.
REQ-031 With AXIOMA_ICP_NOISE_CANCEL_EN undefined, ICNC SHALL read 0, writes to it SHALL be ignored, and no filter logic SHALL be built.

Structure
REQ-032 Register addresses, CS encodings and flag/mask bit indices SHALL live in a shared package/header, axioma_io_pkg, also used by the timers.
REQ-033 The prescaler SHALL be a sub-module, axioma_prescaler, with inputs cs[2:0] and clr and output tick, reusable by the timers.

Verification
REQ-034 CS=001, ICES=1; raise icp_pin while the counter reads 0x0100 -> ICR=0x0100+2 (counter advances during the 3-clk latency), ICF=1, and capture_irq=1 if ICIE=1.
REQ-035 Write CNTH=0xFF then CNTL=0xFE with CS=001 -> TOV sets 2 ticks later; write 0x01 to ICFLG in the same cycle as the wrap -> TOV stays 1.
REQ-036 Two rising edges with no ICF clear between them -> ICR = second value, OVR=1.
REQ-037 ICR=0x12AB captured; read ICRL then a further capture, then read ICRH -> reads return 0xAB then 0x12.
REQ-038 With AXIOMA_ICP_NOISE_CANCEL_EN defined and ICNC=1: a 3-clk pulse -> no capture; a 4-clk pulse -> capture 7 clk after the edge.
REQ-039 With ICES=0, toggle ICES while the pin is high -> no capture; then a falling pin edge -> capture.
